// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-source round-robin arbiter with burst locking.
//
// Generates the 2-bit select for the downstream Mux4 stage. It also runs the
// valid/ready handshake for the muxed stream. A grant is held for up to
// MAX_BURST transfers. After that, priority rotates so that the holder becomes
// the lowest-priority source.
//
// Ports:
//   clk_i        system clock, all state on the rising edge
//   rst_ni       synchronous active-low reset
//   req_i[3:0]   per-source valid (req_i[i] feeds Mux4 din(i+1))
//   ack_o[3:0]   per-source ready, one-hot or zero
//   select_o     registered grant index, drives the Mux4 select
//   out_valid_o  muxed stream valid to the consumer
//   out_ready_i  consumer ready
//   busy_o       high while a grant is held
module rr_arbiter4 #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    output logic [3:0] ack_o,
    output logic [1:0] select_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       busy_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                state_q;
    logic [1:0]            select_q;
    logic [1:0]            last_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [1:0]            winner;
    logic                  found;
    logic                  xfer;
    logic                  burst_last;
    logic                  release_grant;
    logic [CNT_WIDTH-1:0]  cnt_next;

    // Search starts just after the last holder and wraps around to the holder
    // itself. This makes the holder the lowest-priority source.
    always_comb begin
        logic [1:0] idx;
        found  = 1'b0;
        winner = last_q;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign out_valid_o   = (state_q == StGrant) && req_i[select_q];
    assign xfer          = out_valid_o && out_ready_i;
    assign cnt_next      = cnt_q + 1'b1;
    assign burst_last    = (cnt_next == CNT_WIDTH'(MAX_BURST));
    // A dropped request releases the grant even though no transfer happened.
    assign release_grant = (xfer && burst_last) || !req_i[select_q];

    always_comb begin
        ack_o = '0;
        if (xfer) begin
            ack_o[select_q] = 1'b1;
        end
    end

    assign select_o = select_q;
    assign busy_o   = (state_q == StGrant);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            select_q <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        select_q <= winner;
                        last_q   <= winner;
                        cnt_q    <= '0;
                        state_q  <= StGrant;
                    end
                end
                StGrant: begin
                    if (release_grant) begin
                        // Hand over directly, with no bubble between grants.
                        if (found) begin
                            select_q <= winner;
                            last_q   <= winner;
                            cnt_q    <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (xfer) begin
                        cnt_q <= cnt_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-source round-robin arbiter with burst locking.
- Produces the 2-bit select that drives the downstream Mux4 stage, which muxes the four source data buses onto one output stream.
- Runs the valid/ready handshake on behalf of the mux: one ready/ack back to the granted source, one valid forward to the consumer.
- Holds a grant for up to MAX_BURST transfers, then rotates priority.

Parameters:
MAX_BURST, 4, max transfers per grant before forced release; legal range 1..255.
CNT_WIDTH, 8, burst counter width; must hold MAX_BURST.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
req  input  4  per-source valid; req[i] maps to Mux4 din(i+1)
ack  output  4  per-source ready; one-hot or zero
select  output  2  grant index, drives Mux4 select; registered
out_valid  output  1  muxed stream valid to consumer
out_ready  input  1  consumer ready
busy  output  1  high in GRANT state

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - state=IDLE, select=0, last=3, cnt=0.
  - Consequently out_valid=0, ack=0, busy=0.
- Reset mid-burst aborts the grant immediately. No partial state survives.
- States: IDLE, GRANT.
- Arbitration function: search sources (last+1) mod 4, (last+2) mod 4, ... wrapping through last. The first source with req high wins. The current/last holder therefore has lowest priority.
- IDLE:
  - out_valid=0, ack=0.
  - If any req at an edge: select<=winner, last<=winner, cnt<=0, state<=GRANT.
  - Latency: req seen at edge N gives select/out_valid valid after edge N (one bubble from IDLE).
- GRANT (combinational outputs from registered select):
  - out_valid = req[select].
  - ack[select] = req[select] & out_ready; all other ack bits 0.
- Transfer = out_valid & out_ready; cnt increments per transfer.
- Release, evaluated at each edge in GRANT:
  - (a) transfer occurs and cnt+1 == MAX_BURST, or
  - (b) req[select] low (no transfer this cycle).
- On release:
  - If arbitration finds a winner (excluding nothing; current holder is lowest priority), load select/last=winner, cnt=0, stay in GRANT. No bubble between grants.
  - Else state<=IDLE.
- No release: select held stable, cnt holds when out_ready low (backpressure).
- Single requester at burst limit is re-granted to itself with cnt reset. The stream continues without gap.
- Sources must keep req high until ack. A req drop before ack is legal and causes release (b) with zero transfer for that cycle.
- select never changes while out_valid & !out_ready (stability under backpressure).
- ack is never asserted for a non-selected source. ack is never asserted in IDLE.
- MAX_BURST=1 gives strict per-transfer round robin.

Test Plan:
1. Reset: req=4'b1111, out_ready=1, rst_n low 2 cycles -> out_valid=0, ack=0, select=0, busy=0. First cycle after rst_n high: still 0. Next: select=0, ack=4'b0001.
2. Full rotation: MAX_BURST=4, req=4'b1111, out_ready=1 held -> select sequence 0,1,2,3,0 each held exactly 4 cycles. ack one-hot matches select, no zero-valid cycles after first grant.
3. Backpressure: source 2 granted, out_ready low for 3 cycles after 1st transfer -> ack=0, select=2 stable, cnt frozen. Burst completes after 3 more ready cycles (4 total transfers).
4. Early drop: source 1 granted, req[1] falls after 2 transfers, req[3] high -> next edge select=3, ack[3] asserted that cycle, no IDLE cycle.
5. Lone requester: only req[2] high for 10 cycles, out_ready=1 -> select=2 throughout, 9 transfers (1 IDLE bubble), no gap at burst boundaries.
6. Reset mid-burst: rst_n low at 2nd transfer of source 0 grant, req=4'b0011 -> outputs 0 next cycle. After release, first grant is source 0 (last reset to 3).
